// File: rtl/glyph_rain_engine.sv
// rtl/glyph_rain_engine.sv - per-column digital rain engine with frame walk and 2-clock pixel pipeline
module glyph_rain_engine #(
  parameter int          NUM_COLS   = 80,
  parameter int          NUM_ROWS   = 40,
  parameter int          GLYPH_W    = 8,
  parameter int          GLYPH_H    = 12,
  parameter int          NUM_GLYPHS = 51,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int          HPOS_W     = 11,
  parameter int          VPOS_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HPOS_W-1:0] hpos,
  input  logic [VPOS_W-1:0] vpos,
  input  logic              display_on,
  input  logic              frame_tick,
  input  logic              pause,
  input  logic [1:0]        density,
  input  logic [1:0]        pal_sel,
  output logic [5:0]        glyph_idx,
  output logic [2:0]        glyph_x,
  output logic [3:0]        glyph_y,
  input  logic              glyph_pixel,
  output logic [5:0]        rgb,
  output logic              busy,
  output logic              overrun
);
  localparam int HMAX = NUM_ROWS + 19;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int GXW  = $clog2(GLYPH_W);
  localparam int CW   = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int RW   = VPOS_W;

  typedef enum logic {IDLE, WALK} state_t;

  logic [HW-1:0] head [NUM_COLS];
  logic [4:0]    len  [NUM_COLS];
  logic [1:0]    spd  [NUM_COLS];
  logic [1:0]    sub  [NUM_COLS];
  logic [5:0]    seed [NUM_COLS];

  // Row tracking: *_cur is the cell position of the pixel on the inputs right now.
  logic [VPOS_W-1:0] vpos_q;
  logic [3:0]        cy, cy_cur;
  logic [RW-1:0]     row, row_cur;
  logic [5:0]        gm, gm_cur;

  always_comb begin
    cy_cur  = cy;
    row_cur = row;
    gm_cur  = gm;
    if (vpos == '0) begin
      cy_cur  = '0;
      row_cur = '0;
      gm_cur  = '0;
    end else if (vpos != vpos_q) begin
      if (cy == 4'(GLYPH_H - 1)) begin
        cy_cur  = '0;
        row_cur = row + 1'b1;
        gm_cur  = (gm == 6'(NUM_GLYPHS - 1)) ? 6'd0 : gm + 1'b1;
      end else begin
        cy_cur = cy + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpos_q <= '0;
      cy     <= '0;
      row    <= '0;
      gm     <= '0;
    end else begin
      vpos_q <= vpos;
      cy     <= cy_cur;
      row    <= row_cur;
      gm     <= gm_cur;
    end
  end

  state_t        state, state_nx;
  logic [CW-1:0] ptr, ptr_nx;
  logic [15:0]   lfsr, lfsr_nx, lfsr_step;
  logic          col_we;

  assign lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign busy      = (state == WALK);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    lfsr_nx  = lfsr;
    col_we   = 1'b0;
    case (state)
      IDLE: begin
        if (frame_tick) begin
          state_nx = WALK;
          ptr_nx   = '0;
        end
      end
      WALK: begin
        lfsr_nx = lfsr_step;
        col_we  = ~pause;
        if (ptr == CW'(NUM_COLS - 1)) state_nx = IDLE;
        else                          ptr_nx   = ptr + 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      lfsr    <= LFSR_SEED;
      overrun <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      lfsr  <= lfsr_nx;
      if (state == WALK && frame_tick) overrun <= 1'b1;
    end
  end

  // Column update for ptr, driven by the freshly stepped LFSR value.
  logic        active, spawn;
  logic [1:0]  spawn_mask;
  logic [5:0]  seed_raw, seed_new;

  assign active     = 16'(head[ptr]) < (16'(len[ptr]) + 16'(NUM_ROWS));
  assign spawn_mask = (density == 2'd0) ? 2'b00 : (density == 2'd1) ? 2'b01 : 2'b11;
  assign spawn      = (density != 2'd3) && ((lfsr_step[13:12] & spawn_mask) == 2'b00);
  assign seed_raw   = lfsr_step[11:6];
  assign seed_new   = (seed_raw >= 6'(NUM_GLYPHS)) ? seed_raw - 6'(NUM_GLYPHS) : seed_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COLS; i++) begin
        head[i] <= HW'(HMAX);
        len[i]  <= 5'd15;
        spd[i]  <= '0;
        sub[i]  <= '0;
        seed[i] <= '0;
      end
    end else if (col_we) begin
      if (active) begin
        if (sub[ptr] == spd[ptr]) begin
          head[ptr] <= head[ptr] + 1'b1;
          sub[ptr]  <= '0;
        end else begin
          sub[ptr] <= sub[ptr] + 1'b1;
        end
      end else if (spawn) begin
        head[ptr] <= '0;
        sub[ptr]  <= '0;
        spd[ptr]  <= lfsr_step[1:0];
        len[ptr]  <= 5'd4 + {1'b0, lfsr_step[5:2]};
        seed[ptr] <= seed_new;
      end
    end
  end

  // Stage 0: column lookup and glyph addressing.
  logic [HPOS_W-1:0] col;
  logic              col_ok, vis_nx;
  logic [CW-1:0]     cidx;
  logic [6:0]        gsum;
  logic signed [RW:0] d_nx, d_q;
  logic [4:0]        len_q;
  logic              vis_q;

  assign col    = hpos >> GXW;
  assign col_ok = col < HPOS_W'(NUM_COLS);
  assign cidx   = col_ok ? CW'(col) : '0;
  assign gsum   = 7'(seed[cidx]) + 7'(gm_cur);
  assign d_nx   = $signed({1'b0, RW'(head[cidx])}) - $signed({1'b0, row_cur});
  assign vis_nx = display_on && col_ok && (row_cur < RW'(NUM_ROWS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      glyph_idx <= '0;
      glyph_x   <= '0;
      glyph_y   <= '0;
      d_q       <= '0;
      len_q     <= '0;
      vis_q     <= 1'b0;
    end else begin
      glyph_idx <= (gsum >= 7'(NUM_GLYPHS)) ? 6'(gsum - 7'(NUM_GLYPHS)) : 6'(gsum);
      glyph_x   <= 3'(hpos[GXW-1:0]);
      glyph_y   <= cy_cur;
      d_q       <= d_nx;
      len_q     <= len[cidx];
      vis_q     <= vis_nx;
    end
  end

  // Stage 1: ROM bit in, colour out.
  logic [RW-1:0] d_u;
  logic          lit;
  logic [1:0]    lv;
  logic [5:0]    rgb_nx;

  assign d_u = d_q[RW-1:0];
  assign lit = vis_q && glyph_pixel && !d_q[RW] && (d_u < RW'(len_q));
  assign lv  = (d_u < RW'(4)) ? 2'd3 : (d_u < RW'(8)) ? 2'd2 : 2'd1;

  always_comb begin
    rgb_nx = 6'h00;
    if (lit) begin
      if (d_u == '0) begin
        rgb_nx = 6'h3F;
      end else begin
        case (pal_sel)
          2'd0:    rgb_nx = {2'b00, lv, 2'b00};
          2'd1:    rgb_nx = {lv, 1'b0, lv[1], 2'b00};
          2'd2:    rgb_nx = {2'b00, lv, lv};
          default: rgb_nx = {lv, lv, lv};
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rgb <= '0;
    else        rgb <= rgb_nx;
  end
endmodule
